// File: rtl/zx81_tape_pkg.sv
// Shared definitions for the ZX81 cassette pulse player: FSM state codes,
// pulse counts per bit value and default timing in 6.5 MHz clocks.
package zx81_tape_pkg;

  localparam int TIMER_W        = 14;
  localparam int DEF_PULSE_HALF = 975;
  localparam int DEF_BIT_GAP    = 8450;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam logic [7:0] DEF_NAME_BYTE = 8'hA6;

  localparam logic [3:0] PULSES_ZERO = 4'd4;
  localparam logic [3:0] PULSES_ONE  = 4'd9;

  typedef logic [2:0] tape_state_t;
  localparam tape_state_t ST_IDLE     = 3'd0;
  localparam tape_state_t ST_FETCH    = 3'd1;
  localparam tape_state_t ST_PULSE_HI = 3'd2;
  localparam tape_state_t ST_PULSE_LO = 3'd3;
  localparam tape_state_t ST_GAP      = 3'd4;

  // Number of pulses that encode one bit on tape.
  function automatic logic [3:0] pulses_for(input logic bit_val);
    return bit_val ? PULSES_ONE : PULSES_ZERO;
  endfunction

endpackage

// File: rtl/tape_byte_fifo.sv
// Synchronous byte FIFO between the bursty loader and the pulse generator.
// Push into a full FIFO and pop from an empty one are ignored; the pop side
// only ever sees stored data (no write-through bypass).
module tape_byte_fifo
  import zx81_tape_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap on the power-of-two depth.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Control state, cleared by reset.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/zx81_tape_player.sv
// ZX81 cassette pulse player: pops bytes from an input FIFO and emits them
// MSB first as pulse groups (4 pulses for a 0-bit, 9 for a 1-bit), each
// group followed by a silent gap. Dropping play aborts the current byte.
// Optional feature macro ZX81_TAPE_NAME_EN: insert NAME_BYTE as the first
// byte after reset or after a play-abort, without consuming FIFO data.
module zx81_tape_player
  import zx81_tape_pkg::*;
#(
`ifdef ZX81_TAPE_NAME_EN
  parameter logic [7:0] NAME_BYTE = DEF_NAME_BYTE,
`endif
  parameter int PULSE_HALF = DEF_PULSE_HALF,
  parameter int BIT_GAP    = DEF_BIT_GAP,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       play,
  output logic       tape_out,
  output logic       busy
);

  localparam logic [TIMER_W-1:0] HALF_LOAD = TIMER_W'(PULSE_HALF - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(BIT_GAP - 1);

  tape_state_t        state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         pulse_cnt_q, pulse_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  // Bits of the current byte still to be sent after the one on tape.
  logic [6:0]         shift_q, shift_d;
  logic               tape_q, tape_d;
`ifdef ZX81_TAPE_NAME_EN
  logic               name_sent_q, name_sent_d;
`endif

  logic       fifo_full, fifo_empty, fifo_pop;
  logic [7:0] fifo_rd;
  logic [7:0] fetch_byte;
  logic       fetch_pops;
  logic       timer_done;

  tape_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .n_reset   (n_reset),
    .push      (byte_valid),
    .push_data (byte_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign byte_ready = ~fifo_full;
  assign tape_out   = tape_q;
  assign busy       = (state_q != ST_IDLE);
  assign timer_done = (timer_q == '0);

  // Select what FETCH loads: the name byte once per session, else FIFO data.
  always_comb begin
`ifdef ZX81_TAPE_NAME_EN
    fetch_byte = name_sent_q ? fifo_rd : NAME_BYTE;
    fetch_pops = name_sent_q;
`else
    fetch_byte = fifo_rd;
    fetch_pops = 1'b1;
`endif
  end

  // Next-state logic for the pulse sequencer; play low overrides everything.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    pulse_cnt_d = pulse_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    fifo_pop    = 1'b0;
`ifdef ZX81_TAPE_NAME_EN
    name_sent_d = name_sent_q;
`endif
    if (!play) begin
      state_d = ST_IDLE;
`ifdef ZX81_TAPE_NAME_EN
      if (state_q != ST_IDLE) name_sent_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          shift_d     = fetch_byte[6:0];
          bit_cnt_d   = 3'd7;
          pulse_cnt_d = pulses_for(fetch_byte[7]);
          timer_d     = HALF_LOAD;
          state_d     = ST_PULSE_HI;
          fifo_pop    = fetch_pops;
`ifdef ZX81_TAPE_NAME_EN
          name_sent_d = 1'b1;
`endif
        end
        ST_PULSE_HI: begin
          if (timer_done) begin
            state_d = ST_PULSE_LO;
            timer_d = HALF_LOAD;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_PULSE_LO: begin
          if (timer_done) begin
            pulse_cnt_d = pulse_cnt_q - 4'd1;
            if (pulse_cnt_q != 4'd1) begin
              state_d = ST_PULSE_HI;
              timer_d = HALF_LOAD;
            end else begin
              state_d = ST_GAP;
              timer_d = GAP_LOAD;
            end
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_GAP: begin
          if (timer_done) begin
            if (bit_cnt_q != 3'd0) begin
              pulse_cnt_d = pulses_for(shift_q[6]);
              shift_d     = {shift_q[5:0], 1'b0};
              bit_cnt_d   = bit_cnt_q - 3'd1;
              timer_d     = HALF_LOAD;
              state_d     = ST_PULSE_HI;
            end else if (!fifo_empty) begin
              state_d = ST_FETCH;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    tape_d = (state_d == ST_PULSE_HI);
  end

  // Control registers, cleared by reset.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      pulse_cnt_q <= '0;
      bit_cnt_q   <= '0;
      tape_q      <= 1'b0;
`ifdef ZX81_TAPE_NAME_EN
      name_sent_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pulse_cnt_q <= pulse_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tape_q      <= tape_d;
`ifdef ZX81_TAPE_NAME_EN
      name_sent_q <= name_sent_d;
`endif
    end
  end

  // Byte shift register; always reloaded by FETCH before use.
  always_ff @(posedge clock) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_zx81_tape_player.sv
// Bench for zx81_tape_player with shortened timing (PULSE_HALF=3, BIT_GAP=7).
// A tape decoder on the falling clock edge rebuilds bytes from the pulse
// stream and checks them, plus pulse/gap widths, against the pushed bytes.
`timescale 1ns/1ps
module tb_zx81_tape_player;

  localparam int PH    = 3;
  localparam int GAP   = 7;
  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       n_reset = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic       play = 1'b0;
  logic       tape_out;
  logic       busy;

  zx81_tape_player #(.PULSE_HALF(PH), .BIT_GAP(GAP), .FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .n_reset    (n_reset),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .play       (play),
    .tape_out   (tape_out),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic       mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
    end
  endtask

  // ---------------- tape decoder (reference model) ----------------
  int         m_hi, m_lo, m_pulses, m_bits;
  logic [7:0] m_byte;
  logic       m_prev;

  task automatic mon_finish_group();
    logic b;
    check("mon_pulse_count_legal", int'(m_pulses == 4 || m_pulses == 9), 1);
    b        = (m_pulses == 9);
    m_byte   = {m_byte[6:0], b};
    m_bits++;
    m_pulses = 0;
    if (m_bits == 8) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL mon_byte: decoded %0d, none was queued", m_byte);
      end else begin
        check("mon_byte", m_byte, exp_q.pop_front());
      end
      m_bits = 0;
    end
  endtask

  always @(negedge clock) begin
    if (!mon_en) begin
      m_prev = 1'b0; m_hi = 0; m_lo = 1000; m_pulses = 0; m_bits = 0; m_byte = 8'h00;
    end else begin
      if (tape_out) begin
        if (!m_prev) begin
          if (m_pulses > 0)    check("mon_pulse_low", m_lo, PH);
          else if (m_bits > 0) check("mon_bit_gap", m_lo, PH + GAP);
          else                 check("mon_byte_gap_min", int'(m_lo >= PH + GAP + 1), 1);
          m_pulses++;
          m_hi = 0;
        end
        m_hi++;
      end else begin
        if (m_prev) begin
          check("mon_pulse_high", m_hi, PH);
          m_lo = 0;
        end
        m_lo++;
        if (m_pulses > 0 && m_lo == PH + GAP) mon_finish_group();
      end
      m_prev = tape_out;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d, output logic acc);
    byte_data  = d;
    byte_valid = 1'b1;
    acc        = byte_ready;
    if (acc) exp_q.push_back(d);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    while (busy && g < 3000) begin tick(); g++; end
    check(name, busy, 0);
  endtask

  // Counts pulses of the next group; returns once the low run exceeds PH.
  task automatic measure_group(output int n);
    int   lo, g;
    logic prev;
    n = 0; lo = 0; prev = 1'b0; g = 0;
    while (g < 3000) begin
      if (tape_out && !prev) n++;
      if (tape_out) lo = 0; else lo++;
      if (n > 0 && lo > PH) break;
      prev = tape_out;
      tick();
      g++;
    end
    check("group_timeout", int'(g < 3000), 1);
  endtask

  typedef struct {
    logic [7:0] data;
    int         exp_busy;
    int         exp_highs;
  } vec_t;

  initial begin
    vec_t       vecs[6];
    logic [7:0] fill[17];
    logic       acc, prev;
    int         n, g, n_acc, gap_len, v_busy, v_hi;

    // busy = FETCH + 8 bit periods; 0-bit = 31 clocks, 1-bit = 61 clocks
    vecs[0] = '{8'h00, 249, 32};
    vecs[1] = '{8'hFF, 489, 72};
    vecs[2] = '{8'h80, 279, 37};
    vecs[3] = '{8'hA5, 369, 52};
    vecs[4] = '{8'h01, 279, 37};
    vecs[5] = '{8'h7E, 429, 62};

    // Reset state
    n_reset = 1'b0;
    repeat (3) tick();
    check("rst_tape_out", tape_out, 0);
    check("rst_busy", busy, 0);
    check("rst_byte_ready", byte_ready, 1);
    n_reset = 1'b1;
    tick();
    mon_en = 1'b1;

    // Start latency and exact high phase
    push(8'h80, acc);
    play = 1'b1;
    tick();
    check("fetch_busy", busy, 1);
    check("fetch_tape_low", tape_out, 0);
    tick();
    check("first_high", tape_out, 1);
    n = 0;
    while (tape_out && n < 100) begin n++; tick(); end
    check("high_phase_len", n, PH);
    wait_idle("latency_idle");

    // FF then 80 back to back: inter-byte gap stretched by one FETCH clock
    play = 1'b0;
    push(8'hFF, acc);
    push(8'h80, acc);
    play = 1'b1;
    for (int i = 0; i < 8; i++) begin
      measure_group(n);
      check($sformatf("ff_group%0d", i), n, 9);
    end
    gap_len = PH + 1;
    tick();
    g = 0;
    while (!tape_out && g < 200) begin gap_len++; tick(); g++; end
    check("byte_gap_len", gap_len, PH + GAP + 1);
    for (int i = 0; i < 8; i++) begin
      measure_group(n);
      check($sformatf("b80_group%0d", i), n, (i == 0) ? 9 : 4);
    end
    wait_idle("ff80_idle");

    // Fill the FIFO with play low; 17th offer is refused
    play  = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 17; i++) begin
      fill[i] = (i == 0) ? 8'h00 : (i == 1) ? 8'h5A : (i == 2) ? 8'hC3 : 8'($urandom);
      push(fill[i], acc);
      if (acc) n_acc++;
    end
    check("fill_accepted", n_acc, DEPTH);
    check("full_ready_low", byte_ready, 0);
    play = 1'b1;
    tick();
    check("fetch_ready_still_low", byte_ready, 0);
    check("fetch_busy_full", busy, 1);
    tick();
    check("ready_after_pop", byte_ready, 1);

    // Run byte 1 (32 pulses) and stop on the first pulse of byte 2
    n = 0; g = 0; prev = 1'b0;
    while (n < 33 && g < 2000) begin
      tick(); g++;
      if (tape_out && !prev) n++;
      prev = tape_out;
    end
    check("reach_byte2", n, 33);
    check("byte2_high", tape_out, 1);
    mon_en = 1'b0;
    play   = 1'b0;
    void'(exp_q.pop_front());
    tick();
    check("abort_tape_out", tape_out, 0);
    check("abort_busy", busy, 0);

    // 14 bytes kept: exactly two more fit
    n_acc = 0;
    for (int i = 0; i < 3; i++) begin
      push(8'($urandom), acc);
      if (acc) n_acc++;
    end
    check("refill_accepted", n_acc, 2);

    // Restart plays byte 3 (C3) from its MSB
    mon_en = 1'b1;
    play   = 1'b1;
    measure_group(n); check("b3_group0", n, 9);
    measure_group(n); check("b3_group1", n, 9);
    measure_group(n); check("b3_group2", n, 4);

    // Reset while in the gap
    mon_en  = 1'b0;
    n_reset = 1'b0;
    tick();
    check("rst_gap_tape_out", tape_out, 0);
    check("rst_gap_busy", busy, 0);
    check("rst_gap_ready", byte_ready, 1);
    n_reset = 1'b1;
    exp_q.delete();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy) n++;
    end
    check("fifo_empty_after_reset", n, 0);
    mon_en = 1'b1;

    // Table of single bytes: busy length and pulse count
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].data, acc);
      g = 0;
      while (!busy && g < 20) begin tick(); g++; end
      v_busy = 0; v_hi = 0; prev = 1'b0; g = 0;
      while (busy && g < 2000) begin
        v_busy++;
        if (tape_out && !prev) v_hi++;
        prev = tape_out;
        tick();
        g++;
      end
      check($sformatf("vec%0d_busy_len", i), v_busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_pulses", i), v_hi, vecs[i].exp_highs);
    end

    // Random bytes with random spacing, including bursts and underruns
    for (int i = 0; i < 14; i++) begin
      push(8'($urandom), acc);
      repeat ($urandom_range(0, 400)) tick();
    end
    g = 0;
    while ((busy || exp_q.size() != 0) && g < 20000) begin tick(); g++; end
    check("rand_drained", exp_q.size(), 0);
    check("rand_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
